// File: rtl/disp_pkg.sv
// Shared constants for the display arbiter: data width, FSM encoding, clock rate.
package disp_pkg;

  localparam int unsigned DISP_W         = 16;
  localparam int unsigned CYCLES_PER_SEC = 100_000_000;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

endpackage

// File: rtl/disp_arbiter_if.sv
// Requester/display-side bundle of the display arbiter (requests, values, grant, shown number).
interface disp_arbiter_if
  import disp_pkg::*;
#(
  parameter int unsigned NREQ = 3
);

  logic [NREQ-1:0]        req;
  logic [DISP_W*NREQ-1:0] data;
  logic [NREQ-1:0]        gnt;
  logic [DISP_W-1:0]      number;
  logic                   busy;
  logic                   expired;

  modport master (output req, data, input gnt, number, busy, expired);
  modport slave  (input req, data, output gnt, number, busy, expired);

endinterface

// File: rtl/disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from ptr, optionally skipping one index.
module rr_pick #(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [IDX_W-1:0] excl,
  input  logic             excl_en,
  output logic [IDX_W-1:0] win,
  output logic             found
);

  always_comb begin
    int unsigned     idx;
    logic [NREQ-1:0] req_sh;
    win    = '0;
    found  = 1'b0;
    idx    = 0;
    req_sh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx    = (32'(ptr) + i) % NREQ;
      req_sh = req >> idx;
      if (!found && req_sh[0] && !(excl_en && (IDX_W'(idx) == excl))) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner selection for the shared 4-digit display with minimum hold time.
// Optional macro DISP_ARB_PRIO_EN: requester 0 pre-empts any owner and is never expired out.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned NREQ        = 3,
  parameter int unsigned HOLD_CYCLES = CYCLES_PER_SEC,
  parameter int unsigned CNT_W       = 27
) (
  input  logic           clk100,
  input  logic           rst_n,
  disp_arbiter_if.slave  bus
);

  localparam int unsigned       IDX_W    = (NREQ > 2) ? 2 : 1;
  localparam logic [CNT_W-1:0]  HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  LAST     = IDX_W'(NREQ - 1);

  logic [0:0]        state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  rr_ptr;
  logic [CNT_W-1:0]  hold_cnt;
  logic [NREQ-1:0]   gnt;
  logic [DISP_W-1:0] number;

  logic [IDX_W-1:0]  win;
  logic              found;
  logic [NREQ-1:0]   req_sh;
  logic              own_req;
  logic              at_max;
  logic              can_expire;
  logic              grant_new;
  logic              adv_ptr;
  logic              go_idle;
  logic [IDX_W-1:0]  new_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic [DISP_W-1:0] sel_data;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .excl    (owner),
    .excl_en (state == ST_OWN),
    .win     (win),
    .found   (found)
  );

  assign req_sh  = bus.req >> owner;
  assign own_req = req_sh[0];
  assign at_max  = (hold_cnt == HOLD_MAX);

`ifdef DISP_ARB_PRIO_EN
  assign can_expire = (owner != '0);
`else
  assign can_expire = 1'b1;
`endif

  always_comb begin
    grant_new = 1'b0;
    adv_ptr   = 1'b1;
    go_idle   = 1'b0;
    new_idx   = win;
    if (state == ST_IDLE) begin
      grant_new = found;
    end else begin
`ifdef DISP_ARB_PRIO_EN
      if (bus.req[0] && (owner != '0)) begin
        grant_new = 1'b1;
        new_idx   = '0;
        adv_ptr   = 1'b0;
      end else
`endif
      if (!own_req) begin
        grant_new = found;
        go_idle   = !found;
      end else if (at_max && can_expire && found) begin
        grant_new = 1'b1;
      end
    end
  end

  // Constant-index mux: only the selected slice reaches number, so X on other requesters is masked.
  assign sel_idx = grant_new ? new_idx : owner;
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == sel_idx) sel_data = bus.data[DISP_W*i +: DISP_W];
    end
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      number   <= '0;
    end else if (grant_new) begin
      state    <= ST_OWN;
      owner    <= new_idx;
      gnt      <= NREQ'(1) << new_idx;
      number   <= sel_data;
      hold_cnt <= '0;
      if (adv_ptr) rr_ptr <= (new_idx == LAST) ? '0 : new_idx + 1'b1;
    end else if (go_idle) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      hold_cnt <= '0;
    end else if (state == ST_OWN) begin
      number <= sel_data;
      if (!at_max) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.number  = number;
  assign bus.busy    = (state == ST_OWN);
  assign bus.expired = (state == ST_OWN) && at_max;

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed self-checking bench for disp_arbiter with NREQ=3, HOLD_CYCLES=8.
module tb_disp_arbiter;

  logic clk100;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  disp_arbiter_if #(.NREQ(3)) bus ();

  disp_arbiter #(
    .NREQ        (3),
    .HOLD_CYCLES (8),
    .CNT_W       (4)
  ) dut (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk100);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] dv [3];
    int          idx;
    n_tests  = 0;
    n_fail   = 0;
    dv[0]    = 16'h1111;
    dv[1]    = 16'h2222;
    dv[2]    = 16'h3333;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.data = '0;

    // 1: reset state, then idle with no requests
    #2;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_num", 32'(bus.number), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk100);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_gnt", 32'(bus.gnt), 0);
      check("idle_num", 32'(bus.number), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_exp", 32'(bus.expired), 0);
    end

    // 2: single requester, data tracking, X on non-owners, drop to idle
    bus.data = {16'hxxxx, 16'hxxxx, 16'h1234};
    bus.req  = 3'b001;
    tick();
    check("g1_gnt", 32'(bus.gnt), 32'h1);
    check("g1_num", 32'(bus.number), 32'h1234);
    check("g1_busy", 32'(bus.busy), 1);
    check("g1_exp", 32'(bus.expired), 0);
    bus.data = {16'hxxxx, 16'hxxxx, 16'hABCD};
    tick();
    check("g1_track", 32'(bus.number), 32'hABCD);
    bus.req = 3'b000;
    tick();
    check("drop_gnt", 32'(bus.gnt), 0);
    check("drop_num", 32'(bus.number), 32'hABCD);
    check("drop_busy", 32'(bus.busy), 0);

    // 3: all requesting, 8-cycle rotation 0,1,2,0 with no gap
    do_reset();
    bus.data = {dv[2], dv[1], dv[0]};
    bus.req  = 3'b111;
    for (int k = 0; k < 32; k++) begin
      tick();
      idx = (k / 8) % 3;
      check("rr_gnt", 32'(bus.gnt), 32'(3'b001 << idx));
      check("rr_num", 32'(bus.number), 32'(dv[idx]));
      check("rr_exp", 32'(bus.expired), (k % 8 == 7) ? 1 : 0);
    end

    // 4: early release by owner 1 hands straight to 2; sole owner keeps grant past expiry
    do_reset();
    bus.req = 3'b010;
    tick();
    check("own1_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 3'b110;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("own1_hold", 32'(bus.gnt), 32'h2);
    end
    bus.req = 3'b100;
    tick();
    check("early_gnt", 32'(bus.gnt), 32'h4);
    check("early_num", 32'(bus.number), 32'h3333);
    repeat (9) tick();
    check("sole_gnt", 32'(bus.gnt), 32'h4);
    check("sole_exp", 32'(bus.expired), 1);
    bus.req = 3'b000;
    tick();
    check("rel_gnt", 32'(bus.gnt), 0);
    check("rel_exp", 32'(bus.expired), 0);
    check("rel_num", 32'(bus.number), 32'h3333);
    bus.req = 3'b100;
    tick();
    check("rereq_gnt", 32'(bus.gnt), 32'h4);

    // 5: asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", 32'(bus.gnt), 0);
    check("arst_num", 32'(bus.number), 0);
    check("arst_busy", 32'(bus.busy), 0);
    @(negedge clk100);
    rst_n = 1'b1;
    tick();
    check("post_rst_gnt", 32'(bus.gnt), 32'h4);

`ifdef DISP_ARB_PRIO_EN
    // 6: requester 0 pre-empts and is not expired out
    do_reset();
    bus.req = 3'b100;
    tick();
    check("pr_own2", 32'(bus.gnt), 32'h4);
    repeat (2) tick();
    bus.req = 3'b101;
    tick();
    check("pr_preempt", 32'(bus.gnt), 32'h1);
    bus.req = 3'b011;
    for (int c = 0; c < 30; c++) begin
      tick();
      check("pr_keep", 32'(bus.gnt), 32'h1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
